// File: rtl/r32_mem_port_if.sv
// Request/response bus between the R32 core (master) and its memory port (slave).
interface r32_mem_port_if;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        req_write;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output req_address, req_data, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  req_address, req_data, req_write, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/r32_mem_port.sv
// Word-addressed RAM slave for the R32 core bus. Writes are posted; reads go
// through an address stage, a registered RAM read stage and then a small
// fall-through response FIFO so the core can stall responses safely.
module r32_mem_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4
) (
  input logic           clock,
  input logic           reset,
  r32_mem_port_if.slave bus
);
  localparam int PW    = $clog2(RSP_DEPTH) + 1;
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [31:0]           mem [WORDS];
  logic [PW-1:0]         pending;
  logic [ADDR_WIDTH-1:0] word_index;
  logic                  out_of_range;
  logic                  req_ready_int;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_valid_int;
  logic                  rsp_fire;
  logic                  unused_addr_bits;

  logic                  s1_valid;
  logic                  s1_oor;
  logic [ADDR_WIDTH-1:0] s1_index;
  logic                  s2_valid;
  logic                  s2_oor;
  logic [31:0]           ram_q;
  logic [31:0]           s2_data;

  logic [31:0]           fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign word_index       = bus.req_address[ADDR_WIDTH+1:2];
  assign out_of_range     = |bus.req_address[31:ADDR_WIDTH+2];
  assign unused_addr_bits = ^bus.req_address[1:0];

  // Writes stall together with reads once every response slot is claimed.
  assign req_ready_int = !reset && (pending < PW'(RSP_DEPTH));
  assign req_fire      = bus.req_valid && req_ready_int;
  assign rd_fire       = req_fire && !bus.req_write;
  assign wr_fire       = req_fire && bus.req_write && !out_of_range;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign s2_data    = s2_oor ? 32'h0000_0000 : ram_q;

  // The RAM stage output bypasses the FIFO whenever the FIFO is empty and the
  // core is ready, giving one read per cycle with no extra latency.
  assign pop  = !fifo_empty && bus.rsp_ready;
  assign push = s2_valid && !(fifo_empty && bus.rsp_ready);

  assign rsp_valid_int = !reset && (!fifo_empty || s2_valid);
  assign rsp_fire      = rsp_valid_int && bus.rsp_ready;

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = reset       ? 32'h0000_0000 :
                         !fifo_empty ? fifo_mem[rd_ptr[PW-2:0]] :
                         s2_valid    ? s2_data : 32'h0000_0000;

  // Count reads that have been accepted but whose response is not yet taken.
  always_ff @(posedge clock) begin
    if (reset)
      pending <= '0;
    else if (rd_fire && !rsp_fire)
      pending <= pending + PW'(1);
    else if (!rd_fire && rsp_fire)
      pending <= pending - PW'(1);
  end

  // Posted writes; out-of-range writes never reach the array.
  always_ff @(posedge clock) begin
    if (wr_fire)
      mem[word_index] <= bus.req_data;
  end

  // Address stage: capture an accepted read for the RAM on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_index <= '0;
    end else begin
      s1_valid <= rd_fire;
      s1_oor   <= out_of_range;
      s1_index <= word_index;
    end
  end

  // RAM read stage: one cycle of synchronous RAM latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_oor   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_oor   <= s1_oor;
    end
  end

  // Registered RAM read data, only refreshed when a read is in the address stage.
  always_ff @(posedge clock) begin
    if (s1_valid)
      ram_q <= mem[s1_index];
  end

  // Response FIFO storage; push at full is only possible alongside a pop.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr[PW-2:0]] <= s2_data;
  end

  // Response FIFO pointers, wrapping naturally with one extra bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_r32_mem_port.sv
// Randomized and directed stimulus for r32_mem_port, checked every cycle
// against a transaction-level model (word array plus in-order response queue).
module tb_r32_mem_port;
  localparam int ADDR_WIDTH = 10;
  localparam int RSP_DEPTH  = 4;

  logic clock;
  logic reset;
  r32_mem_port_if bus ();

  r32_mem_port #(.ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assertions = 0;
  int failures   = 0;
  int edge_count = 0;
  bit after_reset = 0;

  logic [31:0] model_mem [1 << ADDR_WIDTH];
  logic [31:0] exp_data_q [$];
  int          exp_edge_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, observed, expected, edge_count);
    end
  endtask

  function automatic bit in_range(input logic [31:0] addr);
    return (addr >> (ADDR_WIDTH + 2)) == 0;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % (1 << ADDR_WIDTH));
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] addr,
                               input logic [31:0] data, input logic rr);
    logic exp_ready;
    logic exp_valid;
    bus.req_valid   = v;
    bus.req_write   = w;
    bus.req_address = addr;
    bus.req_data    = data;
    bus.rsp_ready   = rr;
    exp_ready = (exp_data_q.size() < RSP_DEPTH);
    exp_valid = (exp_data_q.size() > 0) && (exp_edge_q[0] <= edge_count);
    @(negedge clock);
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
    if (exp_valid)
      checkOutput("rsp_data", bus.rsp_data, exp_data_q[0]);
    else if (after_reset)
      checkOutput("rsp_data_after_reset", bus.rsp_data, 32'h0);
    after_reset = 0;
    @(posedge clock);
    edge_count++;
    if (exp_valid && rr) begin
      void'(exp_data_q.pop_front());
      void'(exp_edge_q.pop_front());
    end
    if (v && exp_ready) begin
      if (w) begin
        if (in_range(addr))
          model_mem[word_of(addr)] = data;
      end else begin
        exp_data_q.push_back(in_range(addr) ? model_mem[word_of(addr)] : 32'h0);
        exp_edge_q.push_back(edge_count + 1);
      end
    end
    #1;
  endtask

  // One reset cycle with arbitrary request activity that must be ignored.
  task automatic applyReset(input logic v, input logic w, input logic [31:0] addr, input logic [31:0] data);
    reset           = 1'b1;
    bus.req_valid   = v;
    bus.req_write   = w;
    bus.req_address = addr;
    bus.req_data    = data;
    bus.rsp_ready   = 1'b1;
    @(negedge clock);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
    @(posedge clock);
    edge_count++;
    exp_data_q.delete();
    exp_edge_q.delete();
    #1;
    reset = 1'b0;
    after_reset = 1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, rr);
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_address = 32'h0;
    bus.req_data    = 32'h0;
    bus.rsp_ready   = 1'b0;
    @(posedge clock);
    #1;
    applyReset(1'b0, 1'b0, 32'h0, 32'h0);
    applyReset(1'b0, 1'b0, 32'h0, 32'h0);
    idle(1, 1'b1);

    // Initialise the words used by the rest of the test.
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b1);

    // Write then read back on the next cycle.
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Byte offset bits are ignored.
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Five back-to-back reads under backpressure: only four fit.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 32'(32 + i * 4), 32'h0, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Sustained stream of 16 reads with no bubbles.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1);
    idle(3, 1'b1);

    // Pop and accept on the same edge at pending == RSP_DEPTH-1.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 32'(i * 4 + 64), 32'h0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1'b1);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Out-of-range write is ignored and the read returns zero.
    applyStimulus(1'b1, 1'b1, 32'h0001_0000, 32'h0000_0055, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Reset with three buffered responses; the write during reset is dropped.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
    idle(2, 1'b0);
    applyReset(1'b1, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF);
    idle(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Random traffic mixing reads, writes, out-of-range accesses and stalls.
    for (int i = 0; i < 600; i++) begin
      logic        v;
      logic        w;
      logic        rr;
      logic [31:0] addr;
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 9) < 7);
      addr = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        addr = addr | (32'($urandom_range(1, 255)) << 24) | 32'h0000_1000;
      applyStimulus(v, w, addr, $urandom, rr);
    end
    idle(10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
